// File: rtl/imem_port.sv
// Instruction memory fetch port: valid/ready request, optional wait states,
// fault reporting, and a program-load write port that works in any FSM state.
module imem_port #(
   parameter int unsigned DEPTH_WORDS  = 128,
   parameter int unsigned WAIT_STATES  = 0,
   parameter logic [31:0] NOP_INSTR    = 32'h0000_0013,
   parameter string       PRELOAD_FILE = ""
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic [31:0] req_addr_i,
   input  logic        flush_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [31:0] rsp_instr_o,
   output logic [31:0] rsp_addr_o,
   output logic [1:0]  rsp_fault_o,
   input  logic        prog_we_i,
   input  logic [31:0] prog_addr_i,
   input  logic [31:0] prog_data_i
);
   localparam int unsigned IDX_W          = $clog2(DEPTH_WORDS);
   localparam logic [2:0]  WAIT_LOAD      = (WAIT_STATES > 32'd0) ? 3'(WAIT_STATES - 32'd1) : 3'd0;
   localparam logic [1:0]  FAULT_OK       = 2'b00;
   localparam logic [1:0]  FAULT_MISALIGN = 2'b01;
   localparam logic [1:0]  FAULT_RANGE    = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   function automatic logic [1:0] fault_of(input logic [31:0] addr);
      logic [1:0] fault;
      if (addr[1:0] != 2'b00) begin
         fault = FAULT_MISALIGN;
      end else if (addr[31:2] >= 30'(DEPTH_WORDS)) begin
         fault = FAULT_RANGE;
      end else begin
         fault = FAULT_OK;
      end
      return fault;
   endfunction

   state_t            state_r;
   logic [2:0]        cnt_r;
   logic [31:0]       addr_r;
   logic              rsp_valid_r;
   logic [31:0]       rsp_instr_r;
   logic [31:0]       rsp_addr_r;
   logic [1:0]        rsp_fault_r;
   logic [31:0]       mem_r [DEPTH_WORDS];

   logic              req_ready_s;
   logic              accept_s;
   logic              load_s;
   logic [31:0]       load_addr_s;
   logic [1:0]        load_fault_s;
   logic [IDX_W-1:0]  load_idx_s;
   logic [IDX_W-1:0]  prog_idx_s;
   logic              unused_s;

   // Handshake decode and selection of the word loaded into the response registers
   always_comb begin
      req_ready_s  = !flush_i && ((state_r == ST_IDLE) || ((state_r == ST_RESP) && rsp_ready_i));
      accept_s     = req_valid_i && req_ready_s;
      load_addr_s  = accept_s ? req_addr_i : addr_r;
      load_fault_s = fault_of(load_addr_s);
      load_idx_s   = load_addr_s[IDX_W+1:2];
      if (WAIT_STATES == 32'd0) begin
         load_s = accept_s;
      end else begin
         load_s = (state_r == ST_WAIT) && !flush_i && (cnt_r == 3'd0);
      end
   end

   assign prog_idx_s = prog_addr_i[IDX_W+1:2];
   assign unused_s   = ^{prog_addr_i[31:IDX_W+2], prog_addr_i[1:0]};

   // Fetch FSM with registered response; faulted fetches never touch the array
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         cnt_r       <= 3'd0;
         addr_r      <= 32'd0;
         rsp_valid_r <= 1'b0;
         rsp_instr_r <= NOP_INSTR;
         rsp_addr_r  <= 32'd0;
         rsp_fault_r <= FAULT_OK;
      end else begin
         if (load_s) begin
            rsp_addr_r  <= load_addr_s;
            rsp_fault_r <= load_fault_s;
            rsp_instr_r <= (load_fault_s == FAULT_OK) ? mem_r[load_idx_s] : NOP_INSTR;
         end
         case (state_r)
            ST_IDLE, ST_RESP: begin
               if (accept_s) begin
                  addr_r <= req_addr_i;
                  if (WAIT_STATES == 32'd0) begin
                     state_r     <= ST_RESP;
                     rsp_valid_r <= 1'b1;
                  end else begin
                     state_r     <= ST_WAIT;
                     cnt_r       <= WAIT_LOAD;
                     rsp_valid_r <= 1'b0;
                  end
               end else if ((state_r == ST_IDLE) || flush_i || rsp_ready_i) begin
                  state_r     <= ST_IDLE;
                  rsp_valid_r <= 1'b0;
               end
            end
            ST_WAIT: begin
               if (flush_i) begin
                  state_r <= ST_IDLE;
                  cnt_r   <= 3'd0;
               end else if (cnt_r == 3'd0) begin
                  state_r     <= ST_RESP;
                  rsp_valid_r <= 1'b1;
               end else begin
                  cnt_r <= cnt_r - 3'd1;
               end
            end
            default: begin
               state_r     <= ST_IDLE;
               cnt_r       <= 3'd0;
               rsp_valid_r <= 1'b0;
            end
         endcase
      end
   end

   // Program-load write; non-blocking update gives read-before-write on collisions
   always_ff @(posedge clk) begin
      if (prog_we_i) begin
         mem_r[prog_idx_s] <= prog_data_i;
      end
   end

   assign req_ready_o = req_ready_s;
   assign rsp_valid_o = rsp_valid_r;
   assign rsp_instr_o = rsp_instr_r;
   assign rsp_addr_o  = rsp_addr_r;
   assign rsp_fault_o = rsp_fault_r;

endmodule

// File: tb/tb_imem_port.sv
// Bench for imem_port: two instances (0 and 3 wait states) driven by a vector
// table, directed corner sequences and random traffic against a cycle-level model.
module tb_imem_port;
   localparam logic [31:0] NOP   = 32'h0000_0013;
   localparam int          DEPTH = 128;

   typedef struct {
      logic [31:0] addr;
      logic [1:0]  fault;
      logic [31:0] instr;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid [2];
   logic        req_ready [2];
   logic [31:0] req_addr  [2];
   logic        flush     [2];
   logic        rsp_valid [2];
   logic        rsp_ready [2];
   logic [31:0] rsp_instr [2];
   logic [31:0] rsp_addr  [2];
   logic [1:0]  rsp_fault [2];
   logic        prog_we   [2];
   logic [31:0] prog_addr [2];
   logic [31:0] prog_data [2];

   int          vectors     = 0;
   int          miscompares = 0;
   logic [31:0] mdl_mem [2][DEPTH];
   logic [31:0] s_addr [3] = '{32'h0, 32'h4, 32'h8};
   logic [31:0] s_inst [3] = '{32'h07b00093, 32'h00500113, 32'h0badf00d};

   generate
      for (genvar g = 0; g < 2; g++) begin : g_dut
         imem_port #(
            .DEPTH_WORDS (128),
            .WAIT_STATES ((g == 0) ? 0 : 3),
            .NOP_INSTR   (32'h0000_0013),
            .PRELOAD_FILE("")
         ) u_dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .req_valid_i (req_valid[g]),
            .req_ready_o (req_ready[g]),
            .req_addr_i  (req_addr[g]),
            .flush_i     (flush[g]),
            .rsp_valid_o (rsp_valid[g]),
            .rsp_ready_i (rsp_ready[g]),
            .rsp_instr_o (rsp_instr[g]),
            .rsp_addr_o  (rsp_addr[g]),
            .rsp_fault_o (rsp_fault[g]),
            .prog_we_i   (prog_we[g]),
            .prog_addr_i (prog_addr[g]),
            .prog_data_i (prog_data[g])
         );
      end
   endgenerate

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic int ws_of(input int d);
      return (d == 0) ? 0 : 3;
   endfunction

   function automatic logic [1:0] ref_fault(input logic [31:0] a);
      if ((a % 32'd4) != 32'd0) return 2'b01;
      if ((a / 32'd4) >= 32'(DEPTH)) return 2'b10;
      return 2'b00;
   endfunction

   function automatic logic [31:0] rand_addr();
      int sel;
      sel = int'($urandom_range(0, 9));
      if (sel < 8) return 32'($urandom_range(0, DEPTH - 1)) * 32'd4;
      if (sel == 8) return ($urandom() & 32'hFFFF_FFFC) | 32'($urandom_range(1, 3));
      return 32'($urandom_range(DEPTH, 4095)) * 32'd4;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %08h, expected %08h", name, act, exp);
      end
   endtask

   task automatic idle(input int d);
      req_valid[d] = 1'b0;
      req_addr[d]  = 32'd0;
      flush[d]     = 1'b0;
      rsp_ready[d] = 1'b0;
      prog_we[d]   = 1'b0;
      prog_addr[d] = 32'd0;
      prog_data[d] = 32'd0;
   endtask

   // Leaves prog_we high; caller drops it with end_write.
   task automatic write_both(input logic [31:0] a, input logic [31:0] data);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         prog_we[d]   = 1'b1;
         prog_addr[d] = a;
         prog_data[d] = data;
         mdl_mem[d][int'((a / 32'd4) % 32'(DEPTH))] = data;
      end
   endtask

   task automatic end_write();
      @(negedge clk);
      for (int d = 0; d < 2; d++) prog_we[d] = 1'b0;
   endtask

   task automatic fetch(input int d, input logic [31:0] a, input logic [1:0] ef,
                        input logic [31:0] ei, input string tag);
      int lat;
      @(negedge clk);
      req_valid[d] = 1'b1;
      req_addr[d]  = a;
      rsp_ready[d] = 1'b1;
      #1 chk({tag, "_req_ready"}, 32'(req_ready[d]), 32'd1);
      @(negedge clk);
      req_valid[d] = 1'b0;
      req_addr[d]  = $urandom();
      lat = 0;
      while (rsp_valid[d] !== 1'b1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      chk({tag, "_latency"}, 32'(lat), 32'(ws_of(d)));
      chk({tag, "_instr"}, rsp_instr[d], ei);
      chk({tag, "_addr"}, rsp_addr[d], a);
      chk({tag, "_fault"}, 32'(rsp_fault[d]), 32'(ef));
      @(negedge clk);
      chk({tag, "_done"}, 32'(rsp_valid[d]), 32'd0);
      rsp_ready[d] = 1'b0;
   endtask

   initial begin
      vec_t        tbl [9];
      bit          pend, ev, er, rv, rr, fl, we;
      int          ready_at, lat;
      logic [31:0] e_instr, e_addr, ra, pa, pd;
      logic [1:0]  e_fault;

      tbl[0] = '{32'h0000_0000, 2'b00, 32'h07b00093};
      tbl[1] = '{32'h0000_0004, 2'b00, 32'h00500113};
      tbl[2] = '{32'h0000_0008, 2'b00, 32'h0badf00d};
      tbl[3] = '{32'h0000_01FC, 2'b00, 32'h12345678};
      tbl[4] = '{32'h0000_0006, 2'b01, NOP};
      tbl[5] = '{32'h0000_0200, 2'b10, NOP};
      tbl[6] = '{32'h0000_0203, 2'b01, NOP};
      tbl[7] = '{32'hFFFF_FFFC, 2'b10, NOP};
      tbl[8] = '{32'h0000_0001, 2'b01, NOP};

      // Reset values, then req_ready in the first cycle after release
      rst_n = 1'b0;
      idle(0);
      idle(1);
      repeat (2) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk("rst_valid", 32'(rsp_valid[d]), 32'd0);
         chk("rst_instr", rsp_instr[d], NOP);
         chk("rst_addr", rsp_addr[d], 32'd0);
         chk("rst_fault", 32'(rsp_fault[d]), 32'd0);
      end
      @(negedge clk);
      rst_n    = 1'b1;
      flush[1] = 1'b1;
      #1;
      chk("rel_ready_noflush", 32'(req_ready[0]), 32'd1);
      chk("rel_ready_flush", 32'(req_ready[1]), 32'd0);
      @(negedge clk);
      flush[1] = 1'b0;

      for (int i = 0; i < DEPTH; i++) write_both(32'(i) * 32'd4, $urandom());
      for (int i = 0; i < 4; i++) write_both(tbl[i].addr, tbl[i].instr);
      end_write();

      for (int d = 0; d < 2; d++)
         for (int i = 0; i < 9; i++)
            fetch(d, tbl[i].addr, tbl[i].fault, tbl[i].instr, $sformatf("tbl%0d_d%0d", i, d));

      // Consumer stall: response holds, no new request accepted
      for (int d = 0; d < 2; d++) begin
         @(negedge clk);
         req_valid[d] = 1'b1;
         req_addr[d]  = 32'h4;
         @(negedge clk);
         req_addr[d] = 32'h10;
         lat = 0;
         while (rsp_valid[d] !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
         end
         for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            chk("stall_valid", 32'(rsp_valid[d]), 32'd1);
            chk("stall_instr", rsp_instr[d], 32'h00500113);
            chk("stall_addr", rsp_addr[d], 32'h4);
            chk("stall_req_ready", 32'(req_ready[d]), 32'd0);
         end
         req_valid[d] = 1'b0;
         rsp_ready[d] = 1'b1;
         @(negedge clk);
         chk("stall_release", 32'(rsp_valid[d]), 32'd0);
         idle(d);
      end

      // Back-to-back streaming at zero wait states
      @(negedge clk);
      rsp_ready[0] = 1'b1;
      req_valid[0] = 1'b1;
      req_addr[0]  = s_addr[0];
      #1 chk("stream_rdy", 32'(req_ready[0]), 32'd1);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (k < 2) req_addr[0] = s_addr[k+1];
         else req_valid[0] = 1'b0;
         #1;
         chk("stream_valid", 32'(rsp_valid[0]), 32'd1);
         chk("stream_instr", rsp_instr[0], s_inst[k]);
         chk("stream_addr", rsp_addr[0], s_addr[k]);
         if (k < 2) chk("stream_rdy", 32'(req_ready[0]), 32'd1);
      end
      @(negedge clk);
      chk("stream_end", 32'(rsp_valid[0]), 32'd0);
      idle(0);

      // Flush during WAIT discards the fetch and blocks a same-cycle request
      @(negedge clk);
      req_valid[1] = 1'b1;
      req_addr[1]  = 32'h4;
      rsp_ready[1] = 1'b1;
      @(negedge clk);
      req_addr[1] = 32'hC;
      flush[1]    = 1'b1;
      #1 chk("flush_wait_ready", 32'(req_ready[1]), 32'd0);
      @(negedge clk);
      flush[1]     = 1'b0;
      req_valid[1] = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("flush_wait_norsp", 32'(rsp_valid[1]), 32'd0);
      end
      fetch(1, 32'h8, 2'b00, 32'h0badf00d, "flush_next");

      // Flush while a response is presented
      @(negedge clk);
      req_valid[0] = 1'b1;
      req_addr[0]  = 32'h0;
      @(negedge clk);
      req_addr[0] = 32'h4;
      flush[0]    = 1'b1;
      #1;
      chk("flush_resp_valid", 32'(rsp_valid[0]), 32'd1);
      chk("flush_resp_ready", 32'(req_ready[0]), 32'd0);
      @(negedge clk);
      flush[0]     = 1'b0;
      req_valid[0] = 1'b0;
      chk("flush_resp_drop", 32'(rsp_valid[0]), 32'd0);
      @(negedge clk);
      chk("flush_resp_drop2", 32'(rsp_valid[0]), 32'd0);

      // Program load, then write/read collision on one word
      write_both(32'h8, 32'h002081b3);
      end_write();
      fetch(0, 32'h8, 2'b00, 32'h002081b3, "prog_d0");
      fetch(1, 32'h8, 2'b00, 32'h002081b3, "prog_d1");
      @(negedge clk);
      req_valid[0] = 1'b1;
      req_addr[0]  = 32'h8;
      rsp_ready[0] = 1'b1;
      prog_we[0]   = 1'b1;
      prog_addr[0] = 32'h8;
      prog_data[0] = 32'hcafe_0001;
      mdl_mem[0][2] = 32'hcafe_0001;
      @(negedge clk);
      req_valid[0] = 1'b0;
      prog_we[0]   = 1'b0;
      chk("rbw_valid", 32'(rsp_valid[0]), 32'd1);
      chk("rbw_old_data", rsp_instr[0], 32'h002081b3);
      @(negedge clk);
      idle(0);
      fetch(0, 32'h8, 2'b00, 32'hcafe_0001, "rbw_new");

      // Reset in the middle of a wait-state fetch
      @(negedge clk);
      req_valid[1] = 1'b1;
      req_addr[1]  = 32'h4;
      rsp_ready[1] = 1'b1;
      @(negedge clk);
      req_valid[1] = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1 chk("rstmid_instr", rsp_instr[1], NOP);
      @(negedge clk);
      rst_n = 1'b1;
      #1 chk("rstmid_ready", 32'(req_ready[1]), 32'd1);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("rstmid_norsp", 32'(rsp_valid[1]), 32'd0);
      end
      idle(1);

      // Random traffic against a cycle-level transaction model
      for (int d = 0; d < 2; d++) begin
         pend     = 1'b0;
         ready_at = 0;
         e_instr  = NOP;
         e_addr   = 32'd0;
         e_fault  = 2'b00;
         for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            rv = ($urandom_range(0, 9) < 6);
            rr = ($urandom_range(0, 9) < 7);
            fl = ($urandom_range(0, 24) == 0);
            we = ($urandom_range(0, 6) == 0);
            ra = rand_addr();
            pa = $urandom();
            pd = $urandom();
            req_valid[d] = rv;
            req_addr[d]  = ra;
            rsp_ready[d] = rr;
            flush[d]     = fl;
            prog_we[d]   = we;
            prog_addr[d] = pa;
            prog_data[d] = pd;
            #1;
            ev = pend && (c >= ready_at);
            er = !fl && (!pend || (ev && rr));
            chk($sformatf("rnd_d%0d_req_ready", d), 32'(req_ready[d]), 32'(er));
            chk($sformatf("rnd_d%0d_rsp_valid", d), 32'(rsp_valid[d]), 32'(ev));
            if (ev) begin
               chk($sformatf("rnd_d%0d_instr", d), rsp_instr[d], e_instr);
               chk($sformatf("rnd_d%0d_addr", d), rsp_addr[d], e_addr);
               chk($sformatf("rnd_d%0d_fault", d), 32'(rsp_fault[d]), 32'(e_fault));
            end
            if (fl || (ev && rr)) pend = 1'b0;
            if (rv && er) begin
               pend     = 1'b1;
               ready_at = c + 1 + ws_of(d);
               e_addr   = ra;
               e_fault  = ref_fault(ra);
            end
            if (pend && (c + 1 == ready_at))
               e_instr = (e_fault == 2'b00) ? mdl_mem[d][int'(e_addr / 32'd4)] : NOP;
            if (we) mdl_mem[d][int'((pa / 32'd4) % 32'(DEPTH))] = pd;
         end
         @(negedge clk);
         idle(d);
         flush[d] = 1'b1;
         @(negedge clk);
         flush[d] = 1'b0;
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/imem_port.md
IMEM_PORT -- requirements
Module: imem_port

Interface
REQ-001 Parameter DEPTH_WORDS, default 128, number of 32-bit instruction words; SHALL be a power of two, 16..4096.
REQ-002 Parameter WAIT_STATES, default 0, extra cycles between request acceptance and response; legal range 0..7.
REQ-003 Parameter NOP_INSTR, default 32'h00000013, word driven on rsp_instr_o at reset and on faulted responses.
REQ-004 Parameter PRELOAD_FILE, default "", hex image loaded into memory at elaboration when non-empty.
REQ-005 clk  input  1  clock; all state SHALL update on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 req_valid_i  input  1  fetch request valid.
REQ-008 req_ready_o  output  1  fetch request accepted when high with req_valid_i.
REQ-009 req_addr_i  input  32  byte address of fetch.
REQ-010 flush_i  input  1  discard outstanding fetch (branch/redirect).
REQ-011 rsp_valid_o  output  1  response valid.
REQ-012 rsp_ready_i  input  1  consumer accepts response.
REQ-013 rsp_instr_o  output  32  fetched instruction word.
REQ-014 rsp_addr_o  output  32  byte address of the request being answered.
REQ-015 rsp_fault_o  output  2  00 ok, 01 misaligned, 10 out-of-range, 11 unused.
REQ-016 prog_we_i  input  1  program-load write enable.
REQ-017 prog_addr_i  input  32  byte address of write; bits [1:0] ignored.
REQ-018 prog_data_i  input  32  write data.

Function
REQ-019 FSM states IDLE, WAIT, RESP; at most one request outstanding.
REQ-020 req_ready_o SHALL equal !flush_i && (state==IDLE || (state==RESP && rsp_ready_i)).
REQ-021 Accept (req_valid_i && req_ready_o): latch address; go to RESP if WAIT_STATES==0, else WAIT with counter loaded to WAIT_STATES-1.
REQ-022 WAIT: counter decrements each cycle; at 0, go to RESP.
REQ-023 Latency: request accepted at edge N SHALL present rsp_valid_o=1 after edge N+1+WAIT_STATES.
REQ-024 RESP: rsp_valid_o=1; rsp_instr_o, rsp_addr_o, rsp_fault_o SHALL hold stable until rsp_ready_i=1.
REQ-025 RESP with rsp_ready_i=1: new accept same cycle -> back-to-back per REQ-021; otherwise go to IDLE, rsp_valid_o=0 next cycle.
REQ-026 Word index = req_addr_i[31:2]; fault 01 if req_addr_i[1:0]!=0; else fault 10 if index >= DEPTH_WORDS; misaligned takes priority.
REQ-027 Faulted response SHALL drive rsp_instr_o=NOP_INSTR and SHALL NOT read memory.
REQ-028 Memory read SHALL be synchronous, from the latched index.
REQ-029 prog_we_i=1 writes prog_data_i to word prog_addr_i[31:2] mod DEPTH_WORDS at the edge, independent of FSM state.
REQ-030 Same-cycle write and read of one word: read returns old data (read-before-write).
REQ-031 flush_i=1 in WAIT or RESP: next state IDLE, rsp_valid_o=0 next cycle, pending response discarded; a same-cycle request is not accepted.
REQ-032 flush_i=1 in IDLE: no effect beyond forcing req_ready_o=0.
REQ-033 Memory SHALL have no reset; unloaded words read as X in simulation.

Reset
REQ-034 On rst_n=0: state IDLE, rsp_valid_o=0, rsp_instr_o=NOP_INSTR, rsp_addr_o=0, rsp_fault_o=00, wait counter 0.
REQ-035 Reset mid-WAIT/RESP SHALL abort the fetch; no response emitted after release.
REQ-036 req_ready_o SHALL be 1 in the first cycle after release when flush_i=0.

Verification
REQ-037 WAIT_STATES=0, mem[0]=32'h07b00093, addr 0x0 at edge N -> rsp_valid_o=1 after N+1, instr 07b00093, fault 00.
REQ-038 WAIT_STATES=3, addr 0x4 with mem[1]=32'h00500113, rsp_ready_i=1 -> rsp_valid_o rises after N+4, fault 00.
REQ-039 Addr 0x6 -> fault 01, instr 00000013; addr 0x200 at DEPTH_WORDS=128 -> fault 10, instr 00000013.
REQ-040 rsp_ready_i=0 for 5 cycles in RESP -> outputs stable, req_ready_o=0; streaming 0x0,0x4,0x8 at WAIT_STATES=0 with rsp_ready_i=1 -> one response per cycle.
REQ-041 flush_i=1 during WAIT -> no response; next request at 0x8 returns mem[2] with correct rsp_addr_o=0x8.
REQ-042 prog write 32'h002081b3 to 0x8 then fetch 0x8 -> 002081b3; same-cycle write/fetch of 0x8 -> old value.
